pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Drives the pause/flush inputs of every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Sources: load-use hazards, taken branches/jumps from EX, and variable-latency data-memory handshakes in MEM.
//  Holds a MEM-wait FSM with timeout and a stall-cycle performance counter.
// PARAMETERS
//  TIMEOUT   256  max cycles waiting for dmem_ack_i before entering ERR (>=1)
//  CNT_W     32   width of stall_cnt_o
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  id_rs1_i       in   5   ID-stage source register 1
//  id_rs1_re_i    in   1   ID instruction reads rs1
//  id_rs2_i       in   5   ID-stage source register 2
//  id_rs2_re_i    in   1   ID instruction reads rs2
//  ex_wR_i        in   5   EX-stage destination register
//  ex_rf_we_i     in   1   EX instruction writes register file
//  ex_is_load_i   in   1   EX instruction is a load
//  ex_br_taken_i  in   1   EX resolved taken branch/jump (PC redirect)
//  mem_req_i      in   1   MEM stage has an active load/store this cycle
//  dmem_ack_i     in   1   data memory completes the current access
//  pause_pc_o     out  1   hold PC
//  pause_if_id_o  out  1   hold IF_ID
//  pause_id_ex_o  out  1   hold ID_EX
//  pause_ex_mem_o out  1   hold EX_MEM
//  pause_mem_wb_o out  1   hold MEM_WB
//  flush_if_id_o  out  1   load bubble into IF_ID
//  flush_id_ex_o  out  1   load bubble into ID_EX
//  bus_err_o      out  1   sticky: dmem timeout occurred
//  stall_cnt_o    out  CNT_W  cycles with any pause_*_o asserted
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, bus_err_o=0, stall_cnt_o=0; all pause/flush outputs 0.
//  pause/flush outputs are combinational from state + inputs (same-cycle effect); state/counters registered.
//  FSM states:
//   RUN:      mem_req_i & ~dmem_ack_i -> MEM_WAIT, wait_cnt<=1; else stay.
//   MEM_WAIT: dmem_ack_i -> RUN, wait_cnt<=0; else if wait_cnt==TIMEOUT -> ERR; else wait_cnt++.
//   ERR:      terminal until rst_i; bus_err_o=1.
//  Memory stall (RUN & mem_req_i & ~dmem_ack_i, or state MEM_WAIT & ~dmem_ack_i, or ERR):
//   all five pause_* = 1, both flush = 0. Ack in same cycle as req -> zero stall.
//  Load-use (only when not memory-stalled): ex_is_load_i & ex_rf_we_i & ex_wR_i!=0 &
//   ((id_rs1_re_i & id_rs1_i==ex_wR_i) | (id_rs2_re_i & id_rs2_i==ex_wR_i))
//   -> pause_pc=1, pause_if_id=1, flush_id_ex=1; EX_MEM/MEM_WB advance. Exactly one bubble.
//  Branch (only when not memory-stalled): ex_br_taken_i -> flush_if_id=1, flush_id_ex=1, no pauses.
//  Priority: memory stall > branch > load-use. Branch+load-use: branch wins (ID instr is squashed).
//  Branch during memory stall: EX frozen, ex_br_taken_i stays asserted; flush issues on the ack cycle.
//  Register x0 never creates a hazard.
//  flush and pause never both asserted on the same register.
//  stall_cnt_o increments each cycle any pause_* is 1; wraps from 2^CNT_W-1 to 0.
//  rst_i mid-wait: immediate return to RUN, all outputs 0, bus_err_o cleared.
//  Inputs sampled only on the rising edge; outputs depend on present-cycle inputs.
// STRUCTURE
//  Shared package (pipe_pkg): FSM state encoding (ST_RUN, ST_MEM_WAIT, ST_ERR), REG_ZERO=5'd0.
//  Sub-module: hazard_detect (combinational load-use compare). FSM, counters and priority mux stay in the top.
// TESTING
//  1 Reset mid-MEM_WAIT (after 3 wait cycles) -> next cycle state RUN, all outputs 0, stall_cnt_o=0.
//  2 ex_is_load=1, ex_wR=5, id_rs2=5, id_rs2_re=1 -> one cycle: pause_pc=pause_if_id=flush_id_ex=1; next cycle clear.
//  3 ex_wR=0 with load and id_rs1=0 -> no stall. mem_req with ack same cycle -> no pause.
//  4 mem_req, ack after 4 cycles -> 4 cycles all pauses=1; stall_cnt_o +4; RUN after ack.
//  5 TIMEOUT=8, mem_req, no ack -> bus_err_o=1 after 9 cycles; pauses stay 1 until rst_i.
//  6 ex_br_taken + load-use same cycle -> flush_if_id=flush_id_ex=1, pause_pc=0;
//    br_taken during MEM_WAIT -> flushes only on ack cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - state_e   : MEM-wait FSM state encoding
//   - ctrl_t    : bundle of pause/flush controls for the five pipeline registers
//   - REG_ZERO  : architectural x0, which never creates a hazard
//   - reg_match : "ID source reads the register EX is about to write"
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pause_pc;
    logic pause_if_id;
    logic pause_id_ex;
    logic pause_ex_mem;
    logic pause_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 7'b00000_00;
  localparam ctrl_t CTRL_MEM  = 7'b11111_00;
  localparam ctrl_t CTRL_BR   = 7'b00000_11;
  // Hold PC and IF_ID, inject exactly one bubble into ID_EX; EX_MEM/MEM_WB advance.
  localparam ctrl_t CTRL_LU   = 7'b11000_01;

  // A source operand conflicts only when it is actually read and is not x0.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic             src_re,
                                     input logic [REG_W-1:0] dst);
    return src_re && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard sources (ID operands, EX destination/branch, MEM handshake)
// and the pause/flush/status results of the stall/flush controller.
//   master : pipeline side, drives hazard sources, receives controls
//   slave  : controller side, receives hazard sources, drives controls
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic [4:0]       id_rs1_i;
  logic             id_rs1_re_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs2_re_i;
  logic [4:0]       ex_wR_i;
  logic             ex_rf_we_i;
  logic             ex_is_load_i;
  logic             ex_br_taken_i;
  logic             mem_req_i;
  logic             dmem_ack_i;

  logic             pause_pc_o;
  logic             pause_if_id_o;
  logic             pause_id_ex_o;
  logic             pause_ex_mem_o;
  logic             pause_mem_wb_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs1_re_i, id_rs2_i, id_rs2_re_i,
    output ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_br_taken_i,
    output mem_req_i, dmem_ack_i,
    input  pause_pc_o, pause_if_id_o, pause_id_ex_o, pause_ex_mem_o, pause_mem_wb_o,
    input  flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs1_re_i, id_rs2_i, id_rs2_re_i,
    input  ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_br_taken_i,
    input  mem_req_i, dmem_ack_i,
    output pause_pc_o, pause_if_id_o, pause_id_ex_o, pause_ex_mem_o, pause_mem_wb_o,
    output flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector: the ID instruction needs a register that the
// load currently in EX has not produced yet.
//   id_rs1_i/id_rs1_re_i, id_rs2_i/id_rs2_re_i : ID source operands + read enables
//   ex_wr_i, ex_rf_we_i, ex_is_load_i          : EX destination and kind
//   load_use_o                                 : one-bubble stall request
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic             id_rs1_re_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs2_re_i,
  input  logic [REG_W-1:0] ex_wr_i,
  input  logic             ex_rf_we_i,
  input  logic             ex_is_load_i,
  output logic             load_use_o
);

  // Load-use compare; x0 is filtered inside reg_match.
  always_comb begin
    load_use_o = 1'b0;
    if (ex_is_load_i && ex_rf_we_i) begin
      load_use_o = reg_match(id_rs1_i, id_rs1_re_i, ex_wr_i) |
                   reg_match(id_rs2_i, id_rs2_re_i, ex_wr_i);
    end else begin
      load_use_o = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   hz    : pipe_hazard_ctrl_if.slave - hazard sources in, pause/flush,
//           sticky bus_err_o and stall_cnt_o out
// Parameters:
//   TIMEOUT : cycles waited for dmem_ack_i before the terminal ERR state (>=1)
//   CNT_W   : width of the stall-cycle counter
// Pause/flush are combinational from the registered FSM state plus the
// present-cycle inputs; priority is memory stall > branch > load-use.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int unsigned     WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               mem_stall;
  logic               load_use;
  logic               any_pause;
  ctrl_t              ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1_i     (hz.id_rs1_i),
    .id_rs1_re_i  (hz.id_rs1_re_i),
    .id_rs2_i     (hz.id_rs2_i),
    .id_rs2_re_i  (hz.id_rs2_re_i),
    .ex_wr_i      (hz.ex_wR_i),
    .ex_rf_we_i   (hz.ex_rf_we_i),
    .ex_is_load_i (hz.ex_is_load_i),
    .load_use_o   (load_use)
  );

  // MEM-wait FSM next state, wait counter and memory-stall decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // An access acked in its first cycle costs nothing.
        if (hz.mem_req_i && !hz.dmem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
          mem_stall  = 1'b1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_ERR: begin
        state_d   = ST_ERR;
        mem_stall = 1'b1;
      end
      default: begin
        // Corrupted state: freeze the pipeline and flag it like a bus error.
        state_d   = ST_ERR;
        mem_stall = 1'b1;
      end
    endcase
  end

  // Sticky error flag, set on the same edge that enters ERR.
  always_comb begin
    if (state_d == ST_ERR) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // Priority mux: memory stall freezes everything (including a pending branch
  // in EX, which then flushes on the ack cycle); branch squashes ID so it
  // beats load-use.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (mem_stall) begin
      ctrl = CTRL_MEM;
    end else if (hz.ex_br_taken_i) begin
      ctrl = CTRL_BR;
    end else if (load_use) begin
      ctrl = CTRL_LU;
    end else begin
      ctrl = CTRL_IDLE;
    end
  end

  // Stall-cycle counter next value; wraps naturally at 2^CNT_W.
  always_comb begin
    any_pause = ctrl.pause_pc | ctrl.pause_if_id | ctrl.pause_id_ex |
                ctrl.pause_ex_mem | ctrl.pause_mem_wb;
    if (any_pause) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, wait counter, error flag and stall counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WAIT_W{1'b0}};
      bus_err_q   <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pause_pc_o     = ctrl.pause_pc;
  assign hz.pause_if_id_o  = ctrl.pause_if_id;
  assign hz.pause_id_ex_o  = ctrl.pause_id_ex;
  assign hz.pause_ex_mem_o = ctrl.pause_ex_mem;
  assign hz.pause_mem_wb_o = ctrl.pause_mem_wb;
  assign hz.flush_if_id_o  = ctrl.flush_if_id;
  assign hz.flush_id_ex_o  = ctrl.flush_id_ex;
  assign hz.bus_err_o      = bus_err_q;
  assign hz.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench. Expected output vectors are
// {pause_pc, pause_if_id, pause_id_ex, pause_ex_mem, pause_mem_wb,
//  flush_if_id, flush_id_ex, bus_err}; the stall counter is tracked by the bench.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int unsigned TB_CNT_W = 5;

  localparam logic [7:0] E_NONE = 8'b00000_00_0;
  localparam logic [7:0] E_MEM  = 8'b11111_00_0;
  localparam logic [7:0] E_ERR  = 8'b11111_00_1;
  localparam logic [7:0] E_LU   = 8'b11000_01_0;
  localparam logic [7:0] E_BR   = 8'b00000_11_0;

  typedef struct packed {
    logic [4:0] rs1;
    logic       rs1_re;
    logic [4:0] rs2;
    logic       rs2_re;
    logic [4:0] wr;
    logic       we;
    logic       ld;
    logic       br;
    logic       req;
    logic       ack;
  } stim_t;

  logic clk;
  logic rst;

  int errors;
  int checks;
  logic [TB_CNT_W-1:0] exp_cnt;
  logic [7:0] exp_q[$];

  pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz ();

  pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(TB_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [4:0] rs1, input logic rs1_re,
                               input logic [4:0] rs2, input logic rs2_re,
                               input logic [4:0] wr, input logic we, input logic ld,
                               input logic br, input logic req, input logic ack);
    stim_t s;
    s.rs1 = rs1; s.rs1_re = rs1_re; s.rs2 = rs2; s.rs2_re = rs2_re;
    s.wr = wr; s.we = we; s.ld = ld; s.br = br; s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic logic [7:0] obs();
    return {hz.pause_pc_o, hz.pause_if_id_o, hz.pause_id_ex_o, hz.pause_ex_mem_o,
            hz.pause_mem_wb_o, hz.flush_if_id_o, hz.flush_id_ex_o, hz.bus_err_o};
  endfunction

  task automatic set_inputs(input stim_t s);
    hz.id_rs1_i      = s.rs1;
    hz.id_rs1_re_i   = s.rs1_re;
    hz.id_rs2_i      = s.rs2;
    hz.id_rs2_re_i   = s.rs2_re;
    hz.ex_wR_i       = s.wr;
    hz.ex_rf_we_i    = s.we;
    hz.ex_is_load_i  = s.ld;
    hz.ex_br_taken_i = s.br;
    hz.mem_req_i     = s.req;
    hz.dmem_ack_i    = s.ack;
  endtask

  // One pipeline cycle: change inputs just after the rising edge, stop at the falling edge.
  task automatic drive(input stim_t s, input logic [7:0] expv);
    @(posedge clk);
    #1;
    set_inputs(s);
    exp_q.push_back(expv);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_inputs(stim_t'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL reset_outs got=%b want=%b", obs(), E_NONE);
    end
    checks++;
    if (hz.stall_cnt_o !== 5'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d want=0", hz.stall_cnt_o);
    end
    rst = 1'b0;
    exp_cnt = 5'd0;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [7:0] ev[$];
    logic [7:0] want;
    st.push_back(mk(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_LU);
    st.push_back(mk(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_LU);
    st.push_back(mk(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd12, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_LU);
    st.push_back(mk(5'd31, 1'b1, 5'd2, 1'b1, 5'd30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    foreach (st[i]) begin
      drive(st[i], ev[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), want);
      end
      checks++;
      if (hz.stall_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL load_use_cnt[%0d] got=%0d want=%0d", i, hz.stall_cnt_o, exp_cnt);
      end
      if (want[7:3] != 5'd0) exp_cnt++;
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[$];
    logic [7:0] ev[$];
    logic [7:0] want;
    st.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); ev.push_back(E_NONE);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); ev.push_back(E_NONE);
    foreach (st[i]) begin
      drive(st[i], ev[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL zero_stall[%0d] got=%b want=%b", i, obs(), want);
      end
      checks++;
      if (hz.stall_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL zero_stall_cnt[%0d] got=%0d want=%0d", i, hz.stall_cnt_o, exp_cnt);
      end
      if (want[7:3] != 5'd0) exp_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[$];
    logic [7:0] ev[$];
    logic [7:0] want;
    logic [TB_CNT_W-1:0] cnt_before;
    cnt_before = exp_cnt;
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); ev.push_back(E_NONE);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    foreach (st[i]) begin
      drive(st[i], ev[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL mem_wait[%0d] got=%b want=%b", i, obs(), want);
      end
      checks++;
      if (hz.stall_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL mem_wait_cnt[%0d] got=%0d want=%0d", i, hz.stall_cnt_o, exp_cnt);
      end
      if (want[7:3] != 5'd0) exp_cnt++;
    end
    checks++;
    if (hz.stall_cnt_o !== cnt_before + 5'd4) begin
      errors++; $display("FAIL mem_wait_delta got=%0d want=%0d", hz.stall_cnt_o, cnt_before + 5'd4);
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    logic [7:0] ev[$];
    logic [7:0] want;
    st.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)); ev.push_back(E_BR);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); ev.push_back(E_BR);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ev.push_back(E_MEM);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)); ev.push_back(E_BR);
    st.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ev.push_back(E_NONE);
    foreach (st[i]) begin
      drive(st[i], ev[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL branch[%0d] got=%b want=%b", i, obs(), want);
      end
      checks++;
      if (hz.stall_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL branch_cnt[%0d] got=%0d want=%0d", i, hz.stall_cnt_o, exp_cnt);
      end
      if (want[7:3] != 5'd0) exp_cnt++;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] want;
    stim_t req_only;
    req_only = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(req_only, E_MEM);
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL rst_wait_pre[%0d] got=%b want=%b", i, obs(), want);
      end
    end
    set_inputs(stim_t'(0));
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL rst_wait_outs got=%b want=%b", obs(), E_NONE);
    end
    checks++;
    if (hz.stall_cnt_o !== 5'd0) begin
      errors++; $display("FAIL rst_wait_cnt got=%0d want=0", hz.stall_cnt_o);
    end
    #2;
    rst = 1'b0;
    exp_cnt = 5'd0;
    drive(stim_t'(0), E_NONE);
    want = exp_q.pop_front();
    checks++;
    if (obs() !== want) begin
      errors++; $display("FAIL rst_wait_run got=%b want=%b", obs(), want);
    end
    // From RUN a fresh request must stall again and a first-cycle ack must release it.
    drive(req_only, E_MEM);
    want = exp_q.pop_front();
    checks++;
    if (obs() !== want) begin
      errors++; $display("FAIL rst_wait_rereq got=%b want=%b", obs(), want);
    end
    exp_cnt++;
    drive(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), E_NONE);
    want = exp_q.pop_front();
    checks++;
    if (obs() !== want) begin
      errors++; $display("FAIL rst_wait_ack got=%b want=%b", obs(), want);
    end
    checks++;
    if (hz.stall_cnt_o !== exp_cnt) begin
      errors++; $display("FAIL rst_wait_cnt2 got=%0d want=%0d", hz.stall_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] want;
    stim_t s;
    for (int i = 0; i < 40; i++) begin
      if (i < 9) begin
        s = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(s, E_MEM);
      end else begin
        // ERR is terminal: ack, branch and load-use must not release the pipeline.
        s = mk(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0,
               (i % 3 == 0) ? 1'b1 : 1'b0, 1'b1);
        drive(s, E_ERR);
      end
      want = exp_q.pop_front();
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL timeout[%0d] got=%b want=%b", i, obs(), want);
      end
      checks++;
      if (hz.stall_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL timeout_cnt[%0d] got=%0d want=%0d", i, hz.stall_cnt_o, exp_cnt);
      end
      if (want[7:3] != 5'd0) exp_cnt++;
    end
    set_inputs(stim_t'(0));
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== E_NONE) begin
      errors++; $display("FAIL timeout_rst got=%b want=%b", obs(), E_NONE);
    end
    checks++;
    if (hz.stall_cnt_o !== 5'd0) begin
      errors++; $display("FAIL timeout_rst_cnt got=%0d want=0", hz.stall_cnt_o);
    end
    #2;
    rst = 1'b0;
    exp_cnt = 5'd0;
    drive(stim_t'(0), E_NONE);
    want = exp_q.pop_front();
    checks++;
    if (obs() !== want) begin
      errors++; $display("FAIL timeout_after got=%b want=%b", obs(), want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 5'd0;
    rst     = 1'b1;
    set_inputs(stim_t'(0));
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_branch();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
